// File: rtl/addsub_serial_if.sv
// Operand/result handshake bundle for addsub_serial.
// The master side is the operand producer and result consumer; the slave side is the adder.
interface addsub_serial_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf, zero
  );
endinterface

// File: rtl/addsub_serial.sv
// Digit-serial two's-complement adder/subtractor: B+A or B-A, DIGIT bits per cycle.
// Define ADDSUB_SAT_EN to saturate the result to the signed limit on overflow.
module addsub_serial #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input logic            clk,
  input logic            rst_n,
  addsub_serial_if.slave bus
);
  // WIDTH must be a positive multiple of DIGIT.
  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;
`ifdef ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] SatNeg = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SatPos = ~SatNeg;
  logic              bsign_q, bsign_d;
`endif

  logic [DIGIT:0]       dsum;
  logic [WIDTH+DIGIT-1:0] s_cat;
  logic [WIDTH-1:0]     s_shift;
  logic [WIDTH-1:0]     s_fin;
  logic                 ovf_new;

  // One digit of the shared carry chain.
  assign dsum    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
  assign s_cat   = {dsum[DIGIT-1:0], s_q};
  assign s_shift = s_cat[WIDTH+DIGIT-1:DIGIT];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    s_fin   = s_shift;
    // Same-sign operands (after A inversion) giving a different-sign result.
    ovf_new = (a_q[DIGIT-1] ~^ b_q[DIGIT-1]) & (dsum[DIGIT-1] ^ b_q[DIGIT-1]);
`ifdef ADDSUB_SAT_EN
    bsign_d = bsign_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          b_d     = bus.b;
          a_d     = bus.sub ? ~bus.a : bus.a;
          carry_d = bus.sub;
          cnt_d   = '0;
          state_d = StRun;
`ifdef ADDSUB_SAT_EN
          bsign_d = bus.b[WIDTH-1];
`endif
        end
      end
      StRun: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = dsum[DIGIT];
        s_d     = s_shift;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          cout_d = dsum[DIGIT];
          ovf_d  = ovf_new;
`ifdef ADDSUB_SAT_EN
          if (ovf_new) begin
            s_fin = bsign_q ? SatNeg : SatPos;
          end
`endif
          s_d     = s_fin;
          zero_d  = (s_fin == '0);
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
`ifdef ADDSUB_SAT_EN
      bsign_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
`ifdef ADDSUB_SAT_EN
      bsign_q <= bsign_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_addsub_serial.sv
// Randomized bench for addsub_serial: three parameterisations checked against an arithmetic model.
module tb_addsub_serial;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  iv = '0;
  logic [15:0] a_drv = '0;
  logic [15:0] b_drv = '0;
  logic        sub_drv = 1'b0;
  logic        ordy = 1'b0;
  int          sel = 0;

  int n_checks = 0;
  int n_pass   = 0;

  addsub_serial_if #(.WIDTH(16)) if16 ();
  addsub_serial_if #(.WIDTH(8))  if8  ();
  addsub_serial_if #(.WIDTH(12)) if12 ();

  assign if16.in_valid = iv[0];
  assign if16.a = a_drv;
  assign if16.b = b_drv;
  assign if16.sub = sub_drv;
  assign if16.out_ready = ordy;
  assign if8.in_valid = iv[1];
  assign if8.a = a_drv[7:0];
  assign if8.b = b_drv[7:0];
  assign if8.sub = sub_drv;
  assign if8.out_ready = ordy;
  assign if12.in_valid = iv[2];
  assign if12.a = a_drv[11:0];
  assign if12.b = b_drv[11:0];
  assign if12.sub = sub_drv;
  assign if12.out_ready = ordy;

  addsub_serial #(.WIDTH(16), .DIGIT(4)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
  addsub_serial #(.WIDTH(8),  .DIGIT(8)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  addsub_serial #(.WIDTH(12), .DIGIT(3)) u_dut12 (.clk(clk), .rst_n(rst_n), .bus(if12.slave));

  logic [15:0] obs_s;
  logic        obs_c, obs_o, obs_z, obs_iready, obs_ovalid;

  always_comb begin
    obs_s      = if16.s;
    obs_c      = if16.cout;
    obs_o      = if16.ovf;
    obs_z      = if16.zero;
    obs_iready = if16.in_ready;
    obs_ovalid = if16.out_valid;
    if (sel == 1) begin
      obs_s      = {8'h00, if8.s};
      obs_c      = if8.cout;
      obs_o      = if8.ovf;
      obs_z      = if8.zero;
      obs_iready = if8.in_ready;
      obs_ovalid = if8.out_valid;
    end else if (sel == 2) begin
      obs_s      = {4'h0, if12.s};
      obs_c      = if12.cout;
      obs_o      = if12.ovf;
      obs_z      = if12.zero;
      obs_iready = if12.in_ready;
      obs_ovalid = if12.out_valid;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int width_of(input int s);
    return (s == 0) ? 16 : (s == 1) ? 8 : 12;
  endfunction

  function automatic int digits_of(input int s);
    return (s == 1) ? 1 : 4;
  endfunction

  // Plain modular arithmetic with sign-rule overflow.
  task automatic ref_model(input int w, input logic [15:0] bv, input logic [15:0] av,
                           input logic subv, output logic [15:0] es, output logic ec,
                           output logic eo, output logic ez);
    longint unsigned mask, bb, aa, tot, r, half;
    logic sb, sa, sr;
    mask = (64'd1 << w) - 1;
    half = 64'd1 << (w - 1);
    bb   = longint'(bv) & mask;
    aa   = longint'(av) & mask;
    tot  = subv ? (bb + mask + 1 - aa) : (bb + aa);
    r    = tot & mask;
    ec   = ((tot >> w) & 1) != 0;
    sb   = (bb & half) != 0;
    sa   = (aa & half) != 0;
    sr   = (r & half) != 0;
    eo   = subv ? ((sb != sa) && (sr != sb)) : ((sb == sa) && (sr != sb));
`ifdef ADDSUB_SAT_EN
    if (eo) r = sb ? half : (half - 1);
`endif
    es = r[15:0];
    ez = (r == 0);
  endtask

  task automatic start_op(input int s, input logic [15:0] bv, input logic [15:0] av,
                          input logic subv, output logic [15:0] es, output logic ec,
                          output logic eo, output logic ez);
    int lat;
    int wait_cnt;
    sel = s;
    ref_model(width_of(s), bv, av, subv, es, ec, eo, ez);
    wait_cnt = 0;
    #0;
    while (!obs_iready && wait_cnt < 50) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    check("in_ready_before_accept", obs_iready, 1);
    b_drv = bv;
    a_drv = av;
    sub_drv = subv;
    iv[s] = 1'b1;
    @(posedge clk); #1;
    iv = '0;
    lat = 0;
    for (int k = 1; k <= digits_of(s) + 4; k++) begin
      if (obs_ovalid) break;
      @(posedge clk); #1;
      if (obs_ovalid) begin
        lat = k;
        break;
      end
    end
    check("latency", lat, digits_of(s));
    check("s", obs_s, es);
    check("cout", obs_c, ec);
    check("ovf", obs_o, eo);
    check("zero", obs_z, ez);
  endtask

  task automatic finish_op();
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    check("in_ready_after_handshake", obs_iready, 1);
    check("out_valid_after_handshake", obs_ovalid, 0);
  endtask

  logic [15:0] es;
  logic ec, eo, ez;

  initial begin
    sel = 0;
    #12;
    check("rst_in_ready", obs_iready, 1);
    check("rst_out_valid", obs_ovalid, 0);
    check("rst_s", obs_s, 0);
    check("rst_flags", {obs_c, obs_o, obs_z}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    start_op(0, 16'h1234, 16'h0F0F, 1'b0, es, ec, eo, ez);
    check("dir_add_s", obs_s, 16'h2143);
    check("dir_add_flags", {obs_c, obs_o, obs_z}, 3'b000);
    finish_op();
    start_op(0, 16'h0005, 16'h0007, 1'b1, es, ec, eo, ez);
    check("dir_sub_s", obs_s, 16'hFFFE);
    check("dir_sub_cout_ovf", {obs_c, obs_o}, 2'b00);
    finish_op();
    start_op(0, 16'hABCD, 16'hABCD, 1'b1, es, ec, eo, ez);
    check("dir_eq_s", obs_s, 16'h0000);
    check("dir_eq_cout_zero", {obs_c, obs_z}, 2'b11);
    finish_op();
    start_op(0, 16'h7FFF, 16'h0001, 1'b0, es, ec, eo, ez);
    check("dir_povf", obs_o, 1);
`ifdef ADDSUB_SAT_EN
    check("dir_povf_s", obs_s, 16'h7FFF);
`else
    check("dir_povf_s", obs_s, 16'h8000);
`endif
    finish_op();
    start_op(0, 16'h8000, 16'h0001, 1'b1, es, ec, eo, ez);
    check("dir_novf", obs_o, 1);
`ifdef ADDSUB_SAT_EN
    check("dir_novf_s", obs_s, 16'h8000);
`else
    check("dir_novf_s", obs_s, 16'h7FFF);
`endif
    finish_op();

    // Backpressure with ignored input pulses
    start_op(0, 16'h1234, 16'h0F0F, 1'b0, es, ec, eo, ez);
    for (int k = 0; k < 10; k++) begin
      a_drv = 16'($urandom);
      b_drv = 16'($urandom);
      iv[0] = k[0];
      @(posedge clk); #1;
      check("bp_in_ready_low", obs_iready, 0);
    end
    iv = '0;
    check("bp_out_valid", obs_ovalid, 1);
    check("bp_s_stable", obs_s, es);
    check("bp_flags_stable", {obs_c, obs_o, obs_z}, {ec, eo, ez});
    finish_op();
    @(posedge clk); #1;
    check("bp_no_spurious_op", obs_iready, 1);

    // Reset mid-RUN after two digits
    sel = 0;
    b_drv = 16'h1234;
    a_drv = 16'h0F0F;
    sub_drv = 1'b0;
    iv[0] = 1'b1;
    @(posedge clk); #1;
    iv = '0;
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", obs_ovalid, 0);
    check("abort_in_ready", obs_iready, 1);
    check("abort_s", obs_s, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    start_op(0, 16'h0001, 16'h0001, 1'b0, es, ec, eo, ez);
    check("post_abort_s", obs_s, 16'h0002);
    finish_op();

    // Random sweep over all three parameterisations
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 25; k++) begin
        start_op(s, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), es, ec, eo, ez);
        for (int h = 0; h < int'($urandom_range(0, 2)); h++) begin
          @(posedge clk); #1;
        end
        finish_op();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
